// File: rtl/avg_rr_sched.sv
// avg_rr_sched: four-channel block averager sharing one adder via round-robin.
// Each channel accumulates 2^AVE_W samples, then emits floor(sum >> AVE_W)
// tagged with its channel index through one shared valid/ready output register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               clears all channel sums/counters (output untouched)
//   in_data0..3         channel samples
//   in_valid0..3        channel sample valid
//   in_ready0..3        channel grant (sample accepted this cycle)
//   out_data, out_ch    averaged result and its channel index
//   out_valid           result valid
//   out_ready           downstream accepts result
module avg_rr_sched #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AVE_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  input  logic              in_valid0,
  input  logic              in_valid1,
  input  logic              in_valid2,
  input  logic              in_valid3,
  output logic              in_ready0,
  output logic              in_ready1,
  output logic              in_ready2,
  output logic              in_ready3,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned SUM_W = DATA_W + AVE_W;

  logic [DATA_W-1:0] w_in_data [NCH];
  logic [NCH-1:0]    w_in_valid;

  logic [SUM_W-1:0]  r_sum [NCH];
  logic [AVE_W-1:0]  r_cnt [NCH];
  logic [1:0]        r_rr_ptr;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_ch;
  logic              r_out_valid;

  logic              w_out_free;
  logic [NCH-1:0]    w_elig;
  logic [NCH-1:0]    w_grant;
  logic              w_any;
  logic [1:0]        w_gidx;
  logic [1:0]        w_scan;
  logic              w_last;
  logic [SUM_W-1:0]  w_sum_next;

  assign w_in_data[0] = in_data0;
  assign w_in_data[1] = in_data1;
  assign w_in_data[2] = in_data2;
  assign w_in_data[3] = in_data3;
  assign w_in_valid   = {in_valid3, in_valid2, in_valid1, in_valid0};

  // Output slot can take a new result if empty or being drained this cycle.
  assign w_out_free = !r_out_valid || out_ready;

  // A channel on its final sample may only go when the result can be stored.
  always_comb begin : eligibility
    w_elig = '0;
    for (int k = 0; k < NCH; k++) begin
      w_elig[k] = w_in_valid[k] && !rst && !flush &&
                  ((r_cnt[k] != '1) || w_out_free);
    end
  end

  // Round-robin: first eligible channel starting at r_rr_ptr wins.
  always_comb begin : arbiter
    w_grant = '0;
    w_gidx  = r_rr_ptr;
    w_any   = 1'b0;
    w_scan  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_scan = r_rr_ptr + 2'(i);
      if (!w_any && w_elig[w_scan]) begin
        w_grant[w_scan] = 1'b1;
        w_gidx          = w_scan;
        w_any           = 1'b1;
      end
    end
  end

  // Single shared adder, steered to the granted channel.
  assign w_sum_next = r_sum[w_gidx] + SUM_W'(w_in_data[w_gidx]);
  assign w_last     = (r_cnt[w_gidx] == '1);

  assign in_ready0 = w_grant[0];
  assign in_ready1 = w_grant[1];
  assign in_ready2 = w_grant[2];
  assign in_ready3 = w_grant[3];

  // Accumulators, arbitration pointer and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_sum[k] <= '0;
        r_cnt[k] <= '0;
      end
      r_rr_ptr    <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (flush) begin
        for (int k = 0; k < NCH; k++) begin
          r_sum[k] <= '0;
          r_cnt[k] <= '0;
        end
      end else if (w_any) begin
        r_rr_ptr <= w_gidx + 2'd1;
        if (w_last) begin
          r_sum[w_gidx] <= '0;
          r_cnt[w_gidx] <= '0;
        end else begin
          r_sum[w_gidx] <= w_sum_next;
          r_cnt[w_gidx] <= r_cnt[w_gidx] + AVE_W'(1);
        end
      end

      // Completion loads even while the previous result is being accepted.
      if (w_any && w_last) begin
        r_out_data  <= DATA_W'(w_sum_next >> AVE_W);
        r_out_ch    <= w_gidx;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_avg_rr_sched.sv
// Directed bench for avg_rr_sched: reset, single channel, round-robin
// back-to-back results, backpressure, full-scale data, mid-block reset, flush.
module tb_avg_rr_sched;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] d [4];
  logic [3:0]  v;
  logic [3:0]  rdy;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int errs   = 0;
  int checks = 0;

  avg_rr_sched #(.DATA_W(32), .AVE_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data0  (d[0]),
    .in_data1  (d[1]),
    .in_data2  (d[2]),
    .in_data3  (d[3]),
    .in_valid0 (v[0]),
    .in_valid1 (v[1]),
    .in_valid2 (v[2]),
    .in_valid3 (v[3]),
    .in_ready0 (rdy[0]),
    .in_ready1 (rdy[1]),
    .in_ready2 (rdy[2]),
    .in_ready3 (rdy[3]),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v     = '0;
    flush = 1'b0;
    for (int k = 0; k < 4; k++) d[k] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; flush = 1'b0;
    v = 4'hF;
    for (int k = 0; k < 4; k++) d[k] = 32'(k + 1);
    step();
    checks++; if (rdy !== 4'b0000) begin errs++; $display("FAIL reset_ready: got %b expected %b", rdy, 4'b0000); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errs++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    checks++; if (out_ch !== 2'd0) begin errs++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
    step();
    checks++; if (rdy !== 4'b0000) begin errs++; $display("FAIL reset_ready2: got %b expected %b", rdy, 4'b0000); end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      v[0] = 1'b1; d[0] = 32'(i);
      #1;
      checks++; if (rdy !== 4'b0001) begin errs++; $display("FAIL single_ready[%0d]: got %b expected 0001", i, rdy); end
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_early_valid[%0d]: got %b expected 0", i, out_valid); end
      step();
    end
    v = '0;
    checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'd4) begin errs++; $display("FAIL single_data: got %0d expected 4", out_data); end
    checks++; if (out_ch !== 2'd0) begin errs++; $display("FAIL single_ch: got %0d expected 0", out_ch); end
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] ev;
    do_reset();
    out_ready = 1'b1;
    d[0] = 32'd10; d[1] = 32'd20; d[2] = 32'd30; d[3] = 32'd40;
    v = 4'hF;
    for (int c = 0; c < 32; c++) begin
      #1;
      ev = 4'(1 << (c % 4));
      checks++; if (rdy !== ev) begin errs++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, rdy, ev); end
      if (c >= 29) begin
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'(c - 29) || out_data !== 32'(10 * (c - 28)))
          begin errs++; $display("FAIL rr_result[%0d]: got v=%b ch=%0d d=%0d expected v=1 ch=%0d d=%0d",
                                  c, out_valid, out_ch, out_data, c - 29, 10 * (c - 28)); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rr_early_valid[%0d]: got %b expected 0", c, out_valid); end
      end
      step();
    end
    v = '0;
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 32'd40)
      begin errs++; $display("FAIL rr_last: got v=%b ch=%0d d=%0d expected v=1 ch=3 d=40", out_valid, out_ch, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rr_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v[2] = 1'b1; d[2] = 32'd6;
      step();
    end
    v = '0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd6 || out_ch !== 2'd2)
      begin errs++; $display("FAIL bp_pending: got v=%b ch=%0d d=%0d expected v=1 ch=2 d=6", out_valid, out_ch, out_data); end
    for (int i = 0; i < 7; i++) begin
      v[0] = 1'b1; d[0] = 32'd5;
      #1;
      checks++; if (rdy !== 4'b0001) begin errs++; $display("FAIL bp_fill[%0d]: got %b expected 0001", i, rdy); end
      step();
    end
    v[1] = 1'b1; d[1] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rdy !== 4'b0010) begin errs++; $display("FAIL bp_stall[%0d]: got %b expected 0010", i, rdy); end
      checks++; if (out_valid !== 1'b1 || out_data !== 32'd6 || out_ch !== 2'd2)
        begin errs++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%0d expected v=1 ch=2 d=6", i, out_valid, out_ch, out_data); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (rdy !== 4'b0001) begin errs++; $display("FAIL bp_release: got %b expected 0001", rdy); end
    step();
    v = '0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd5 || out_ch !== 2'd0)
      begin errs++; $display("FAIL bp_result: got v=%b ch=%0d d=%0d expected v=1 ch=0 d=5", out_valid, out_ch, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_full_scale();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v[2] = 1'b1; d[2] = 32'hFFFF_FFFF;
      step();
    end
    v = '0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_ch !== 2'd2)
      begin errs++; $display("FAIL max_result: got v=%b ch=%0d d=%0h expected v=1 ch=2 d=ffffffff", out_valid, out_ch, out_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v[1] = 1'b1; d[1] = 32'd100;
      step();
    end
    rst = 1'b1;
    #1;
    checks++; if (rdy !== 4'b0000) begin errs++; $display("FAIL rstmid_ready: got %b expected 0000", rdy); end
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    // Pointer was 2 before reset; a cleared pointer favours ch1 over ch3.
    v[1] = 1'b1; d[1] = 32'd8;
    v[3] = 1'b1; d[3] = 32'd77;
    #1;
    checks++; if (rdy !== 4'b0010) begin errs++; $display("FAIL rstmid_ptr: got %b expected 0010", rdy); end
    step();
    v[3] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++; if (rdy !== 4'b0010 || out_valid !== 1'b0)
        begin errs++; $display("FAIL rstmid_fill[%0d]: got rdy=%b v=%b expected rdy=0010 v=0", i, rdy, out_valid); end
      step();
    end
    v = '0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd8 || out_ch !== 2'd1)
      begin errs++; $display("FAIL rstmid_result: got v=%b ch=%0d d=%0d expected v=1 ch=1 d=8", out_valid, out_ch, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_single: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v[0] = 1'b1; d[0] = 32'd24;
      step();
    end
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[3] = 1'b1; d[3] = 32'd50;
      #1;
      checks++; if (rdy !== 4'b1000) begin errs++; $display("FAIL flush_pre[%0d]: got %b expected 1000", i, rdy); end
      step();
    end
    flush = 1'b1;
    #1;
    checks++; if (rdy !== 4'b0000) begin errs++; $display("FAIL flush_ready: got %b expected 0000", rdy); end
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd24 || out_ch !== 2'd0)
      begin errs++; $display("FAIL flush_keep: got v=%b ch=%0d d=%0d expected v=1 ch=0 d=24", out_valid, out_ch, out_data); end
    d[3] = 32'd16;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++; if (rdy !== 4'b1000) begin errs++; $display("FAIL flush_refill[%0d]: got %b expected 1000", i, rdy); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (rdy !== 4'b1000) begin errs++; $display("FAIL flush_final: got %b expected 1000", rdy); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd24 || out_ch !== 2'd0)
      begin errs++; $display("FAIL flush_drain: got v=%b ch=%0d d=%0d expected v=1 ch=0 d=24", out_valid, out_ch, out_data); end
    step();
    v = '0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd16 || out_ch !== 2'd3)
      begin errs++; $display("FAIL flush_result: got v=%b ch=%0d d=%0d expected v=1 ch=3 d=16", out_valid, out_ch, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_scale();
    test_reset_mid();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
